// File: rtl/auv_plic.sv
// auv_plic: priority interrupt controller with threshold, edge/level modes and claim/complete.
// Define AUV_PLIC_SYNC_EN to pass irq_input through a 2-flop synchroniser.
module auv_plic #(
  parameter int INT_COUNT  = 16,
  parameter int PRIO_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INT_COUNT-1:0] irq_input,
  output logic                 int_ext,
  input  logic                 cbus_sel,
  input  logic [3:0]           cbus_adr,
  input  logic [31:0]          cbus_dat_wr,
  output logic [31:0]          cbus_dat_rd,
  input  logic                 cbus_rd,
  input  logic                 cbus_wr,
  output logic                 cbus_ack
);
  logic [INT_COUNT-1:0]  enable, mode, pending, in_service, irq_prev, samp;
  logic [INT_COUNT-1:0]  claim_mask, cmp_mask, w1c, in_service_n, pend_n;
  logic [PRIO_WIDTH-1:0] threshold, best_p;
  logic [PRIO_WIDTH-1:0] prio [INT_COUNT];
  logic [5:0]            win_id;
  logic [31:0]           rd_val;
  logic                  req, wr_req, rd_req, unused_ok;
`ifdef AUV_PLIC_SYNC_EN
  logic [INT_COUNT-1:0] sync1, sync2;
  always_ff @(posedge clk)
    if (!rst_n) {sync2, sync1} <= '0;
    else        {sync2, sync1} <= {sync1, irq_input};
  assign samp = sync2;
`else
  assign samp = irq_input;
`endif
  assign unused_ok = ^cbus_dat_wr;
  assign req    = cbus_sel & (cbus_rd | cbus_wr) & ~cbus_ack;
  assign wr_req = req & cbus_wr;
  assign rd_req = req & ~cbus_wr;
  // Strict compare keeps the lowest index on priority ties; starting at threshold enforces prio > THRESHOLD.
  always_comb begin
    best_p = threshold;
    win_id = '0;
    for (int i = 0; i < INT_COUNT; i++)
      if (pending[i] && enable[i] && !in_service[i] && prio[i] > best_p) begin
        best_p = prio[i];
        win_id = 6'(i + 1);
      end
  end
  always_comb begin
    claim_mask = '0;
    cmp_mask   = '0;
    for (int i = 0; i < INT_COUNT; i++) begin
      claim_mask[i] = rd_req && cbus_adr == 4'd4 && win_id == 6'(i + 1);
      cmp_mask[i]   = wr_req && cbus_adr == 4'd4 && cbus_dat_wr[5:0] == 6'(i + 1);
    end
    w1c          = (wr_req && cbus_adr == 4'd0) ? cbus_dat_wr[INT_COUNT-1:0] : '0;
    in_service_n = (in_service | claim_mask) & ~cmp_mask;
    pend_n       = (mode & ((pending & ~w1c & ~claim_mask) | (samp & ~irq_prev)))
                 | (~mode & samp & ~in_service_n);
  end
  always_comb begin
    rd_val = '0;
    case (cbus_adr)
      4'd0:    rd_val = 32'(pending);
      4'd1:    rd_val = 32'(enable);
      4'd2:    rd_val = 32'(mode);
      4'd3:    rd_val = 32'(threshold);
      4'd4:    rd_val = 32'(win_id);
      default: rd_val = '0;
    endcase
    for (int n = 0; n < INT_COUNT; n++)
      if (cbus_adr == 4'(8 + n / 8)) rd_val[4*(n%8) +: PRIO_WIDTH] = prio[n];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable      <= '0;
      mode        <= '0;
      threshold   <= '0;
      pending     <= '0;
      in_service  <= '0;
      irq_prev    <= '0;
      int_ext     <= 1'b0;
      cbus_ack    <= 1'b0;
      cbus_dat_rd <= '0;
      for (int n = 0; n < INT_COUNT; n++) prio[n] <= '0;
    end else begin
      cbus_ack    <= req;
      cbus_dat_rd <= rd_req ? rd_val : '0;
      int_ext     <= win_id != '0;
      irq_prev    <= samp;
      pending     <= pend_n;
      in_service  <= in_service_n;
      if (wr_req && cbus_adr == 4'd1) enable    <= cbus_dat_wr[INT_COUNT-1:0];
      if (wr_req && cbus_adr == 4'd2) mode      <= cbus_dat_wr[INT_COUNT-1:0];
      if (wr_req && cbus_adr == 4'd3) threshold <= cbus_dat_wr[PRIO_WIDTH-1:0];
      for (int n = 0; n < INT_COUNT; n++)
        if (wr_req && cbus_adr == 4'(8 + n / 8)) prio[n] <= cbus_dat_wr[4*(n%8) +: PRIO_WIDTH];
    end
  end
endmodule

// File: tb/tb_auv_plic.sv
// tb_auv_plic: directed stimulus with an in-bench reference model of auv_plic checked every cycle.
module tb_auv_plic;
  localparam int N  = 16;
  localparam int PW = 3;
`ifdef AUV_PLIC_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  logic          clk = 0, rst_n = 0;
  logic [N-1:0]  irq_input = '0;
  logic          int_ext, cbus_sel = 0, cbus_rd = 0, cbus_wr = 0, cbus_ack;
  logic [3:0]    cbus_adr = '0;
  logic [31:0]   cbus_dat_wr = '0, cbus_dat_rd, q;
  int            total = 0, passed = 0, k;
  auv_plic #(.INT_COUNT(N), .PRIO_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .irq_input(irq_input), .int_ext(int_ext),
    .cbus_sel(cbus_sel), .cbus_adr(cbus_adr), .cbus_dat_wr(cbus_dat_wr),
    .cbus_dat_rd(cbus_dat_rd), .cbus_rd(cbus_rd), .cbus_wr(cbus_wr), .cbus_ack(cbus_ack)
  );
  always #5 clk = ~clk;
  // Reference model: per-source state held in plain arrays
  logic [N-1:0] m_pend, m_en, m_mode, m_ins, m_prev, q1, q2;
  int           m_thr, m_prio [N];
  logic         m_ack, m_int, mvalid = 0;
  logic [31:0]  m_rd;
  function automatic int winner();
    int best, id;
    best = m_thr;
    id = 0;
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_en[i] && !m_ins[i] && m_prio[i] > best) begin
        best = m_prio[i];
        id = i + 1;
      end
    return id;
  endfunction
  function automatic logic [31:0] regread(input logic [3:0] a, input int w);
    logic [31:0] r;
    r = 0;
    if (a == 0) r = 32'(m_pend);
    if (a == 1) r = 32'(m_en);
    if (a == 2) r = 32'(m_mode);
    if (a == 3) r = 32'(m_thr);
    if (a == 4) r = 32'(w);
    for (int n = 0; n < N; n++)
      if (int'(a) == 8 + n / 8) r = r | (32'(m_prio[n]) << (4 * (n % 8)));
    return r;
  endfunction
  always @(posedge clk) begin
    int w;
    logic [N-1:0] s;
    logic rq, iw, ir, cl, cp, wc;
    if (!rst_n) begin
      {m_pend, m_en, m_mode, m_ins, m_prev, q1, q2} = '0;
      m_thr = 0;
      for (int n = 0; n < N; n++) m_prio[n] = 0;
      m_ack = 0;
      m_int = 0;
      m_rd = 0;
      mvalid = 1;
    end else begin
      w = winner();
      rq = cbus_sel && (cbus_rd || cbus_wr) && !m_ack;
      iw = rq && cbus_wr;
      ir = rq && !cbus_wr;
      m_rd = ir ? regread(cbus_adr, w) : 32'd0;
      m_ack = rq;
      m_int = w != 0;
`ifdef AUV_PLIC_SYNC_EN
      s = q2;
      q2 = q1;
      q1 = irq_input;
`else
      s = irq_input;
`endif
      for (int i = 0; i < N; i++) begin
        cl = ir && cbus_adr == 4 && w == i + 1;
        cp = iw && cbus_adr == 4 && int'(cbus_dat_wr[5:0]) == i + 1;
        wc = iw && cbus_adr == 0 && cbus_dat_wr[i];
        m_ins[i] = (m_ins[i] || cl) && !cp;
        if (m_mode[i]) m_pend[i] = (m_pend[i] && !(wc || cl)) || (s[i] && !m_prev[i]);
        else           m_pend[i] = s[i] && !m_ins[i];
      end
      m_prev = s;
      if (iw && cbus_adr == 1) m_en = cbus_dat_wr[N-1:0];
      if (iw && cbus_adr == 2) m_mode = cbus_dat_wr[N-1:0];
      if (iw && cbus_adr == 3) m_thr = int'(cbus_dat_wr) & ((1 << PW) - 1);
      for (int n = 0; n < N; n++)
        if (iw && int'(cbus_adr) == 8 + n / 8)
          m_prio[n] = int'(cbus_dat_wr >> (4 * (n % 8))) & ((1 << PW) - 1);
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  always @(negedge clk)
    if (mvalid) begin
      chk("int_ext_model", 32'(int_ext), 32'(m_int));
      chk("ack_model", 32'(cbus_ack), 32'(m_ack));
      chk("rdata_model", cbus_dat_rd, m_rd);
    end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic acc(input logic w, input logic [3:0] a, input logic [31:0] d, output logic [31:0] r);
    cbus_sel = 1;
    cbus_wr = w;
    cbus_rd = !w;
    cbus_adr = a;
    cbus_dat_wr = d;
    @(posedge clk);
    #1;
    chk("ack_latency", 32'(cbus_ack), 32'd1);
    r = cbus_dat_rd;
    cbus_sel = 0;
    cbus_rd = 0;
    cbus_wr = 0;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r;
    acc(1, a, d, r);
  endtask
  task automatic rd(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] r;
    acc(0, a, 32'd0, r);
    chk(name, r, exp);
  endtask
  initial begin
    idle(3);
    rst_n = 1;
    idle(1);
    foreach (k_list[j]) rd("reset_read", k_list[j], 32'd0);
    chk("reset_int_ext", 32'(int_ext), 32'd0);
    // edge source 3 (ID 4): latency, claim, pending cleared
    wr(2, 32'h8);
    wr(1, 32'h8);
    wr(8, 32'h5000);
    wr(3, 32'd2);
    irq_input[3] = 1;
    for (k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) irq_input[3] = 0;
      if (int_ext) break;
    end
    chk("edge_latency", 32'(k), 32'(LAT));
    rd("claim_src3", 4, 32'd4);
    chk("int_ext_drop", 32'(int_ext), 32'd0);
    rd("pending_after_claim", 0, 32'd0);
    wr(4, 32'd4);
    // level sources 1 and 6: tie then priority raise
    wr(2, 32'd0);
    wr(1, 32'h42);
    wr(8, 32'h0300_0030);
    irq_input = 16'h0042;
    idle(LAT + 1);
    rd("claim_tie", 4, 32'd2);
    wr(4, 32'd2);
    wr(8, 32'h0700_0030);
    idle(2);
    rd("claim_prio7", 4, 32'd7);
    wr(4, 32'd7);
    irq_input = '0;
    idle(LAT + 1);
    // level source 0 held high while in service
    wr(1, 32'h1);
    wr(8, 32'h1);
    wr(3, 32'd0);
    irq_input = 16'h1;
    idle(LAT + 1);
    chk("level_int", 32'(int_ext), 32'd1);
    rd("claim_src0", 4, 32'd1);
    idle(3);
    chk("in_service_quiet", 32'(int_ext), 32'd0);
    wr(4, 32'd0);
    wr(4, 32'd40);
    chk("bad_complete", 32'(int_ext), 32'd0);
    rd("level_pend_forced", 0, 32'd0);
    wr(4, 32'd1);
    chk("reassert", 32'(int_ext), 32'd1);
    irq_input = '0;
    wr(1, 32'd0);
    idle(LAT + 1);
    // edge source 2: edge during service, W1C collision
    wr(2, 32'h4);
    wr(1, 32'h4);
    wr(8, 32'h400);
    irq_input[2] = 1;
    idle(1);
    irq_input[2] = 0;
    idle(LAT);
    rd("claim_src2", 4, 32'd3);
    irq_input[2] = 1;
    idle(1);
    irq_input[2] = 0;
    idle(LAT);
    rd("pend_in_service", 0, 32'h4);
    wr(4, 32'd3);
    rd("claim_again", 4, 32'd3);
    wr(4, 32'd3);
    irq_input[2] = 1;
    idle(1);
    irq_input[2] = 0;
    idle(LAT);
    irq_input[2] = 1;
    idle(LAT - 2);
    wr(0, 32'h4);
    rd("w1c_vs_edge", 0, 32'h4);
    wr(0, 32'h4);
    rd("w1c_clear", 0, 32'h0);
    irq_input = '0;
    // threshold at max priority blocks everything
    wr(2, 32'd0);
    wr(1, 32'hFFFF);
    wr(8, 32'h7777_7777);
    wr(9, 32'h7777_7777);
    wr(3, 32'hFF);
    irq_input = '1;
    idle(LAT + 1);
    chk("thr_block", 32'(int_ext), 32'd0);
    rd("claim_none", 4, 32'd0);
    rd("thr_mask", 3, 32'd7);
    rd("prio_word9", 9, 32'h7777_7777);
    rd("unmapped", 12, 32'd0);
    // reset during an outstanding read
    cbus_sel = 1;
    cbus_rd = 1;
    cbus_adr = 1;
    rst_n = 0;
    idle(1);
    chk("reset_no_ack", 32'(cbus_ack), 32'd0);
    cbus_sel = 0;
    cbus_rd = 0;
    irq_input = '0;
    rst_n = 1;
    idle(1);
    rd("reset_enable", 1, 32'd0);
    rd("reset_prio", 8, 32'd0);
    rd("reset_thr", 3, 32'd0);
    chk("reset_int", 32'(int_ext), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  logic [3:0] k_list [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8};
endmodule
